// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle between the binary value source and bin2bcd_seq.
// Signal names match the converter's original port list.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  i_start;
  logic [BIN_W-1:0]      i_bin;
  logic                  i_lzb;
  logic [4*DIGITS-1:0]   o_bcd;
  logic [DIGITS-1:0]     o_blank;
  logic                  o_ovf;
  logic                  o_idle;
  logic                  o_done;

  modport master (
    output i_start, i_bin, i_lzb,
    input  o_bcd, o_blank, o_ovf, o_idle, o_done
  );

  modport slave (
    input  i_start, i_bin, i_lzb,
    output o_bcd, o_blank, o_ovf, o_idle, o_done
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per clock, with
// start/done handshake, saturating overflow and leading-zero blanking mask.
module bin2bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  bin2bcd_seq_if.slave  bus
);
  localparam int unsigned BW      = 4 * DIGITS;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = int'(10 ** DIGITS) - 1;
  localparam logic [BW-1:0] SAT   = {DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              r_state;
  logic [BIN_W-1:0]    r_bin;
  logic [BW-1:0]       r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ovf_f;
  logic                r_lzb_f;
  logic [BW-1:0]       r_bcd_o;
  logic [DIGITS-1:0]   r_blank;
  logic                r_ovf;
  logic                r_idle;
  logic                r_done;

  logic [BW-1:0]       w_adj;
  logic [BW+BIN_W-1:0] w_cat;
  logic [BW-1:0]       w_bcd_nxt;
  logic [BIN_W-1:0]    w_bin_nxt;
  logic [DIGITS-1:0]   w_blank;
  logic                w_zero;
  logic                w_ovf_in;

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
    w_cat     = {w_adj, r_bin} << 1;
    w_bcd_nxt = w_cat[BW+BIN_W-1 -: BW];
    w_bin_nxt = w_cat[BIN_W-1:0];
  end

  // Blank mask is taken from the post-shift value so it publishes with the last shift.
  always_comb begin
    w_blank = '0;
    w_zero  = 1'b1;
    for (int unsigned j = DIGITS - 1; j >= 1; j--) begin
      w_zero     = w_zero & (w_bcd_nxt[4*j +: 4] == 4'd0);
      w_blank[j] = w_zero & r_lzb_f & ~r_ovf_f;
    end
  end

  assign w_ovf_in = 32'(bus.i_bin) > MAX_VAL;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_ovf_f <= 1'b0;
      r_lzb_f <= 1'b0;
      r_bcd_o <= '0;
      r_blank <= '0;
      r_ovf   <= 1'b0;
      r_idle  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            r_bin   <= bus.i_bin;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_ovf_f <= w_ovf_in;
            r_lzb_f <= bus.i_lzb;
            r_idle  <= 1'b0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= w_bin_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_ovf   <= r_ovf_f;
            r_bcd_o <= r_ovf_f ? SAT : w_bcd_nxt;
            r_blank <= w_blank;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_bcd   = r_bcd_o;
  assign bus.o_blank = r_blank;
  assign bus.o_ovf   = r_ovf;
  assign bus.o_idle  = r_idle;
  assign bus.o_done  = r_done;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomised self-checking bench for bin2bcd_seq across four parameter sets,
// checked against a decimal arithmetic reference model.
module tb_bin2bcd_seq;
  localparam int W_TAB [4] = '{14, 20, 4, 1};
  localparam int D_TAB [4] = '{4, 6, 1, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [35:0] last_bcd [4];

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(14), .DIGITS(4)) if0 ();
  bin2bcd_seq_if #(.BIN_W(20), .DIGITS(6)) if1 ();
  bin2bcd_seq_if #(.BIN_W(4),  .DIGITS(1)) if2 ();
  bin2bcd_seq_if #(.BIN_W(1),  .DIGITS(1)) if3 ();

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0.slave));
  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1.slave));
  bin2bcd_seq #(.BIN_W(4),  .DIGITS(1)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2.slave));
  bin2bcd_seq #(.BIN_W(1),  .DIGITS(1)) u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: digits by division, saturation and blanking by magnitude comparison.
  task automatic model(input int d, input longint v, input bit lzb,
                       output logic [35:0] bcd, output logic [8:0] blank, output bit ovf);
    longint p;
    p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    ovf   = (v > p - 1);
    bcd   = '0;
    blank = '0;
    p     = 1;
    for (int k = 0; k < d; k++) begin
      bcd[4*k +: 4] = ovf ? 4'h9 : 4'((v / p) % 10);
      if (k >= 1 && lzb && !ovf && v < p) blank[k] = 1'b1;
      p = p * 10;
    end
  endtask

  task automatic drive(input int sel, input bit s, input longint v, input bit l);
    case (sel)
      0: begin if0.i_start = s; if0.i_bin = 14'(v); if0.i_lzb = l; end
      1: begin if1.i_start = s; if1.i_bin = 20'(v); if1.i_lzb = l; end
      2: begin if2.i_start = s; if2.i_bin = 4'(v);  if2.i_lzb = l; end
      default: begin if3.i_start = s; if3.i_bin = 1'(v); if3.i_lzb = l; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0: return if0.o_done;
      1: return if1.o_done;
      2: return if2.o_done;
      default: return if3.o_done;
    endcase
  endfunction

  function automatic logic get_idle(input int sel);
    case (sel)
      0: return if0.o_idle;
      1: return if1.o_idle;
      2: return if2.o_idle;
      default: return if3.o_idle;
    endcase
  endfunction

  function automatic logic get_ovf(input int sel);
    case (sel)
      0: return if0.o_ovf;
      1: return if1.o_ovf;
      2: return if2.o_ovf;
      default: return if3.o_ovf;
    endcase
  endfunction

  function automatic logic [35:0] get_bcd(input int sel);
    case (sel)
      0: return 36'(if0.o_bcd);
      1: return 36'(if1.o_bcd);
      2: return 36'(if2.o_bcd);
      default: return 36'(if3.o_bcd);
    endcase
  endfunction

  function automatic logic [8:0] get_blank(input int sel);
    case (sel)
      0: return 9'(if0.o_blank);
      1: return 9'(if1.o_blank);
      2: return 9'(if2.o_blank);
      default: return 9'(if3.o_blank);
    endcase
  endfunction

  task automatic run(input int sel, input longint v, input bit lzb);
    logic [35:0] eb;
    logic [8:0]  ebl;
    bit          eo;
    int          lat;
    bit          seen;
    model(D_TAB[sel], v, lzb, eb, ebl, eo);
    @(negedge clk);
    drive(sel, 1'b1, v, lzb);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, longint'($urandom), 1'($urandom));
    check("idle_low", get_idle(sel), 1'b0);
    check("hold", get_bcd(sel), last_bcd[sel]);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
      if (get_done(sel)) seen = 1;
    end
    check("done_seen", seen, 1'b1);
    if (seen) begin
      check("latency", lat, W_TAB[sel]);
      check("bcd", get_bcd(sel), eb);
      check("blank", get_blank(sel), ebl);
      check("ovf", get_ovf(sel), eo);
      last_bcd[sel] = eb;
      @(posedge clk);
      #1;
      check("done_pulse", get_done(sel), 1'b0);
      check("idle_back", get_idle(sel), 1'b1);
    end
  endtask

  initial begin
    logic [35:0] gb;
    int dcnt;
    int lowcnt;
    for (int s = 0; s < 4; s++) begin
      drive(s, 1'b0, 0, 1'b0);
      last_bcd[s] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_bcd", get_bcd(0), 36'h0);
    check("rst_blank", get_blank(0), 9'h0);
    check("rst_ovf", get_ovf(0), 1'b0);
    check("rst_done", get_done(0), 1'b0);
    check("rst_idle", get_idle(0), 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 0, 1'b0);
    run(0, 9999, 1'b0);
    run(0, 10000, 1'b1);
    run(0, 16383, 1'b1);
    run(0, 42, 1'b1);
    run(0, 7, 1'b1);
    run(0, 305, 1'b1);
    run(0, 0, 1'b1);
    run(0, 1000, 1'b1);

    // start ignored while busy, including on the DONE cycle
    @(negedge clk);
    drive(0, 1'b1, 1234, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 5678, 1'b0);
    lowcnt = get_idle(0) ? 0 : 1;
    dcnt   = 0;
    gb     = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      drive(0, (c == 3 || c == 15), 5678, 1'b0);
      @(posedge clk);
      #1;
      if (get_done(0)) begin
        dcnt++;
        gb = get_bcd(0);
      end
      if (!get_idle(0)) lowcnt++;
    end
    drive(0, 1'b0, 0, 1'b0);
    check("busy_dones", dcnt, 1);
    check("busy_bcd", gb, 36'h1234);
    check("busy_idle_low", lowcnt, 15);
    last_bcd[0] = 36'h1234;

    // asynchronous reset mid-conversion
    @(negedge clk);
    drive(0, 1'b1, 9876, 1'b0);
    @(posedge clk);
    #1;
    drive(0, 1'b0, 0, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_bcd", get_bcd(0), 36'h0);
    check("arst_idle", get_idle(0), 1'b1);
    check("arst_done", get_done(0), 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (get_done(0)) dcnt++;
    end
    check("arst_no_done", dcnt, 0);
    for (int s = 0; s < 4; s++) last_bcd[s] = '0;
    run(0, 55, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if (i % 10 == 0) run(0, longint'($urandom_range(9990, 10010)), 1'($urandom));
      else             run(0, longint'($urandom_range(0, 16383)), 1'($urandom));
    end

    run(1, 999999, 1'b0);
    run(1, 1000000, 1'b0);
    for (int i = 0; i < 30; i++) run(1, longint'($urandom_range(0, 1048575)), 1'($urandom));
    run(2, 9, 1'b0);
    run(2, 15, 1'b1);
    for (int i = 0; i < 20; i++) run(2, longint'($urandom_range(0, 15)), 1'($urandom));
    run(3, 1, 1'b0);
    run(3, 0, 1'b1);
    for (int i = 0; i < 6; i++) run(3, longint'($urandom_range(0, 1)), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
